// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the CSR register file.
// CSR addresses, field positions, exception codes, write-merge helper.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_PLV  = 0;
  localparam int CRMD_IE   = 2;
  localparam int CRMD_DA   = 3;
  localparam int CRMD_PG   = 4;
  localparam int IS_TI     = 11;
  localparam int IS_IPI    = 12;
  localparam int ECODE_LO  = 16;
  localparam int ESUB_LO   = 22;
  localparam int EENTRY_LO = 6;
  localparam int TCFG_EN   = 0;
  localparam int TCFG_PER  = 1;

  localparam logic [12:0] LIE_MASK = 13'h1bff;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

  function automatic logic [31:0] wmerge(
    input logic [31:0] old,
    input logic [31:0] mask,
    input logic [31:0] val
  );
    return (old & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if: write-back stage CSR access port.
// master is the write-back stage, slave is the register file.
interface csr_regfile_if;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_rvalue
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_rvalue
  );
endinterface

// File: rtl/csr_timer.sv
// csr_timer: TCFG/TVAL constant timer.
// ti_set pulses while enabled and TVAL has reached zero.
module csr_timer
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        ti_set
);

  logic [31:0] reload;

  assign reload = {tcfg[31:2], 2'b00};
  assign ti_set = tcfg[TCFG_EN] & (tval == 32'h0);

  // Config load, expiry reload/stop, or countdown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg <= '0;
      tval <= '1;
    end else if (tcfg_we) begin
      tcfg <= tcfg_wdata;
      tval <= {tcfg_wdata[31:2], 2'b00};
    end else if (ti_set) begin
      tval <= tcfg[TCFG_PER] ? reload : '1;
    end else if (tcfg[TCFG_EN] && tval != '1) begin
      tval <= tval - 32'd1;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch CSR file behind the write-back CSR port.
// Handles masked writes, exception/ERTN commits, interrupts, timer.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic         clk,
  input  logic         resetn,
  csr_regfile_if.slave bus,
  input  logic         wb_ex,
  input  logic         ertn_flush,
  input  logic [5:0]   wb_ecode,
  input  logic [8:0]   wb_esubcode,
  input  logic [31:0]  wb_pc,
  input  logic [31:0]  wb_vaddr,
  input  logic [7:0]   hw_int_in,
  input  logic         ipi_int_in,
  output logic [31:0]  ex_entry,
  output logic [31:0]  ertn_entry,
  output logic         has_int
);

  logic [1:0]  crmd_plv;
  logic        crmd_ie, crmd_da, crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ti, is_ipi;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] era, badv, tid;
  logic [25:0] eentry;
  logic [31:0] save [4];
  logic [31:0] tcfg, tval;
  logic        ti_set;
  logic        wr, ticlr_clr;
  logic [31:0] rdata, new_w;

  // Lower-priority commits are dropped.
  assign wr = bus.csr_we & ~wb_ex & ~ertn_flush;

  assign estat_is = {is_ipi, is_ti, 1'b0, is_hw, is_sw};
  assign new_w = wmerge(rdata, bus.csr_wmask, bus.csr_wvalue);
  assign ticlr_clr = wr && bus.csr_num == CSR_TICLR
    && bus.csr_wmask[0] && bus.csr_wvalue[0];

  // Combinational read mux; unmapped addresses read 0.
  always_comb begin
    rdata = '0;
    case (bus.csr_num)
      CSR_CRMD:
        rdata = {27'b0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   rdata = {29'b0, prmd_pie, prmd_pplv};
      CSR_ECFG:   rdata = {19'b0, ecfg_lie};
      CSR_ESTAT:
        rdata = {1'b0, estat_esub, estat_ecode, 3'b0, estat_is};
      CSR_ERA:    rdata = era;
      CSR_BADV:   rdata = badv;
      CSR_EENTRY: rdata = {eentry, 6'b0};
      CSR_SAVE0:  rdata = save[0];
      CSR_SAVE1:  rdata = save[1];
      CSR_SAVE2:  rdata = save[2];
      CSR_SAVE3:  rdata = save[3];
      CSR_TID:    rdata = tid;
      CSR_TCFG:   rdata = tcfg;
      CSR_TVAL:   rdata = tval;
      default:    rdata = '0;
    endcase
  end

  assign bus.csr_rvalue = rdata;

  // Mode/return state: exception, then ERTN, then SW write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_plv    <= '0;
      crmd_ie     <= 1'b0;
      crmd_da     <= 1'b1;
      crmd_pg     <= 1'b0;
      prmd_pplv   <= '0;
      prmd_pie    <= 1'b0;
      estat_ecode <= '0;
      estat_esub  <= '0;
      era         <= '0;
      badv        <= '0;
    end else if (wb_ex) begin
      prmd_pplv   <= crmd_plv;
      prmd_pie    <= crmd_ie;
      crmd_plv    <= '0;
      crmd_ie     <= 1'b0;
      estat_ecode <= wb_ecode;
      estat_esub  <= wb_esubcode;
      era         <= wb_pc;
      if (wb_ecode == ECODE_ADEF)
        badv <= wb_pc;
      else if (wb_ecode == ECODE_ALE)
        badv <= wb_vaddr;
    end else if (ertn_flush) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else if (wr) begin
      case (bus.csr_num)
        CSR_CRMD:
          {crmd_pg, crmd_da, crmd_ie, crmd_plv} <= new_w[4:0];
        CSR_PRMD: {prmd_pie, prmd_pplv} <= new_w[2:0];
        CSR_ERA:  era  <= new_w;
        CSR_BADV: badv <= new_w;
        default: ;
      endcase
    end
  end

  // Software-only registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ecfg_lie <= '0;
      eentry   <= '0;
      tid      <= TID_INIT;
      for (int i = 0; i < 4; i++) save[i] <= '0;
    end else if (wr) begin
      case (bus.csr_num)
        CSR_ECFG:   ecfg_lie <= new_w[12:0] & LIE_MASK;
        CSR_EENTRY: eentry <= new_w[31:EENTRY_LO];
        CSR_TID:    tid <= new_w;
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          save[bus.csr_num[1:0]] <= new_w;
        default: ;
      endcase
    end
  end

  // Interrupt status: sampled lines, SW bits, sticky timer bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_sw  <= '0;
      is_hw  <= '0;
      is_ti  <= 1'b0;
      is_ipi <= 1'b0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (ti_set)
        is_ti <= 1'b1;
      else if (ticlr_clr)
        is_ti <= 1'b0;
      if (wr && bus.csr_num == CSR_ESTAT)
        is_sw <= new_w[1:0];
    end
  end

  csr_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (wr && bus.csr_num == CSR_TCFG),
    .tcfg_wdata (new_w),
    .tcfg       (tcfg),
    .tval       (tval),
    .ti_set     (ti_set)
  );

  assign ex_entry   = {eentry, 6'b0};
  assign ertn_entry = era;
  assign has_int    = crmd_ie & (|(estat_is & ecfg_lie));

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: vector table, directed corner cases and
// randomized traffic checked against a behavioural CSR model.
module tb_csr_regfile;

  typedef struct {
    logic        we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wval;
    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [7:0]  hw;
    logic        ipi;
  } stim_t;

  typedef struct {
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wval;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_ex = 1'b0;
  logic        ertn_flush = 1'b0;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_vaddr = '0;
  logic [7:0]  hw_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic [31:0] ex_entry, ertn_entry;
  logic        has_int;

  int total = 0;
  int bad = 0;

  logic [31:0] m [128];
  logic [13:0] addrs [18];

  csr_regfile_if bus ();

  csr_regfile #(.TID_INIT(32'h0)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .wb_ex       (wb_ex),
    .ertn_flush  (ertn_flush),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .has_int     (has_int)
  );

  always #50 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wmask_of(input logic [13:0] a);
    case (a)
      14'h000: return 32'h0000_001f;
      14'h001: return 32'h0000_0007;
      14'h004: return 32'h0000_1bff;
      14'h005: return 32'h0000_0003;
      14'h00c: return 32'hffff_ffc0;
      14'h006, 14'h007, 14'h030, 14'h031, 14'h032, 14'h033,
      14'h040, 14'h041: return 32'hffff_ffff;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [13:0] a);
    if (a == 14'h042) return m[7'h42];
    if (wmask_of(a) != 0) return m[a[6:0]];
    return 32'h0;
  endfunction

  function automatic logic exp_has_int();
    return m[0][2] & (|(m[5][12:0] & m[4][12:0]));
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.we = 0; s.num = '0; s.mask = '0; s.wval = '0;
    s.ex = 0; s.ertn = 0; s.ecode = '0; s.esub = '0;
    s.pc = '0; s.vaddr = '0; s.hw = '0; s.ipi = 0;
    return s;
  endfunction

  function automatic stim_t wr_stim(input logic [13:0] a,
                                    input logic [31:0] mk,
                                    input logic [31:0] v);
    stim_t s;
    s = idle();
    s.we = 1; s.num = a; s.mask = mk; s.wval = v;
    return s;
  endfunction

  function automatic stim_t ex_stim(input logic [5:0] ec,
                                    input logic [31:0] pc,
                                    input logic [31:0] va);
    stim_t s;
    s = idle();
    s.ex = 1; s.ecode = ec; s.pc = pc; s.vaddr = va;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m[i] = '0;
    m[7'h00] = 32'h8;
    m[7'h42] = 32'hffff_ffff;
    m[7'h40] = 32'h0;
  endtask

  // Next architectural state from the current one and this cycle's inputs.
  task automatic model_step(input stim_t s);
    logic [31:0] crmd, prmd, tcfg, tval, wm, e;
    logic ti, clr, tw;
    crmd = m[7'h00]; prmd = m[7'h01];
    tcfg = m[7'h41]; tval = m[7'h42];
    ti = tcfg[0] && tval == 32'h0;
    clr = 0; tw = 0;
    if (s.ex) begin
      m[7'h01] = {29'b0, crmd[2], crmd[1:0]};
      m[7'h00] = crmd & ~32'h7;
      m[7'h05][30:16] = {s.esub, s.ecode};
      m[7'h06] = s.pc;
      if (s.ecode == 6'h08) m[7'h07] = s.pc;
      else if (s.ecode == 6'h09) m[7'h07] = s.vaddr;
    end else if (s.ertn) begin
      m[7'h00] = (crmd & ~32'h7) | (prmd & 32'h7);
    end else if (s.we) begin
      wm = wmask_of(s.num) & s.mask;
      if (wm != 0)
        m[s.num[6:0]] = (m[s.num[6:0]] & ~wm) | (s.wval & wm);
      if (s.num == 14'h041) tw = 1;
      if (s.num == 14'h044 && s.mask[0] && s.wval[0]) clr = 1;
    end
    if (tw) m[7'h42] = {m[7'h41][31:2], 2'b00};
    else if (ti) m[7'h42] = tcfg[1] ? {tcfg[31:2], 2'b00} : 32'hffff_ffff;
    else if (tcfg[0] && tval != 32'hffff_ffff) m[7'h42] = tval - 1;
    e = m[7'h05];
    e[9:2] = s.hw;
    e[12] = s.ipi;
    if (ti) e[11] = 1'b1;
    else if (clr) e[11] = 1'b0;
    m[7'h05] = e;
  endtask

  task automatic drive(input stim_t s);
    bus.csr_we = s.we; bus.csr_num = s.num;
    bus.csr_wmask = s.mask; bus.csr_wvalue = s.wval;
    wb_ex = s.ex; ertn_flush = s.ertn;
    wb_ecode = s.ecode; wb_esubcode = s.esub;
    wb_pc = s.pc; wb_vaddr = s.vaddr;
    hw_int_in = s.hw; ipi_int_in = s.ipi;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    @(posedge clk);
    model_step(s);
    #1;
    bus.csr_we = 0; wb_ex = 0; ertn_flush = 0;
  endtask

  task automatic do_reset();
    drive(idle());
    resetn = 0;
    repeat (2) @(posedge clk);
    #20;
    resetn = 1;
    model_reset();
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] v);
    bus.csr_num = a;
    #1;
    v = bus.csr_rvalue;
  endtask

  task automatic chk_rd(input string name, input logic [13:0] a);
    logic [31:0] v;
    rd(a, v);
    chk($sformatf("%s@%0h", name, a), v, exp_rd(a));
  endtask

  task automatic chk_const(input string name, input logic [13:0] a,
                           input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic chk_out();
    chk("has_int", {31'b0, has_int}, {31'b0, exp_has_int()});
    chk("ex_entry", ex_entry, m[7'h0c]);
    chk("ertn_entry", ertn_entry, m[7'h06]);
  endtask

  initial begin
    vec_t vt [14];
    stim_t s;
    logic [31:0] v;
    int first;
    logic exp_hi;

    addrs = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
              14'h00c, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040,
              14'h041, 14'h042, 14'h044, 14'h002, 14'h043, 14'h1000};

    vt[0]  = '{14'h000, 32'h0000_0003, 32'h0000_0007, 32'h0000_000b};
    vt[1]  = '{14'h005, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0003};
    vt[2]  = '{14'h004, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_1bff};
    vt[3]  = '{14'h00c, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffc0};
    vt[4]  = '{14'h001, 32'hffff_ffff, 32'h0000_00ff, 32'h0000_0007};
    vt[5]  = '{14'h032, 32'hffff_0000, 32'hdead_beef, 32'hdead_0000};
    vt[6]  = '{14'h040, 32'hffff_ffff, 32'h1234_5678, 32'h1234_5678};
    vt[7]  = '{14'h042, 32'hffff_ffff, 32'h0000_0055, 32'hffff_ffff};
    vt[8]  = '{14'h002, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000};
    vt[9]  = '{14'h044, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    vt[10] = '{14'h000, 32'h0000_0008, 32'h0000_0000, 32'h0000_0003};
    vt[11] = '{14'h006, 32'h0f0f_0f0f, 32'ha5a5_a5a5, 32'h0505_0505};
    vt[12] = '{14'h1000, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000};
    vt[13] = '{14'h000, 32'h0000_0000, 32'hffff_ffff, 32'h0000_0003};

    // reset map
    do_reset();
    chk_const("rst_crmd", 14'h000, 32'h8);
    chk_const("rst_tval", 14'h042, 32'hffff_ffff);
    chk("rst_ex_entry", ex_entry, 32'h0);
    chk("rst_ertn_entry", ertn_entry, 32'h0);
    chk("rst_has_int", {31'b0, has_int}, 32'h0);
    foreach (addrs[i]) chk_rd("rst_map", addrs[i]);

    // masked write vectors
    foreach (vt[i]) begin
      step(wr_stim(vt[i].num, vt[i].mask, vt[i].wval));
      rd(vt[i].num, v);
      chk($sformatf("vec%0d", i), v, vt[i].exp);
    end

    // exception with a same-cycle write, then return
    do_reset();
    step(wr_stim(14'h00c, 32'hffff_ffff, 32'h1c00_8000));
    chk("eentry_out", ex_entry, 32'h1c00_8000);
    step(wr_stim(14'h000, 32'h7, 32'h7));
    s = ex_stim(6'h0b, 32'h1c00_0100, 32'h0);
    s.we = 1; s.num = 14'h030; s.mask = '1; s.wval = 32'hcafe_f00d;
    step(s);
    chk_const("ex_prmd", 14'h001, 32'h7);
    chk_const("ex_crmd", 14'h000, 32'h8);
    chk_const("ex_era", 14'h006, 32'h1c00_0100);
    chk_const("ex_save0", 14'h030, 32'h0);
    chk_const("ex_estat", 14'h005, 32'h000b_0000);
    chk("ex_ertn_entry", ertn_entry, 32'h1c00_0100);
    s = idle();
    s.ertn = 1;
    step(s);
    chk_const("ertn_crmd", 14'h000, 32'hf);

    // BADV source by ecode
    step(ex_stim(6'h09, 32'h1c00_0200, 32'h1234_5677));
    chk_const("badv_ale", 14'h007, 32'h1234_5677);
    step(ex_stim(6'h08, 32'h8000_0002, 32'h5555_5555));
    chk_const("badv_adef", 14'h007, 32'h8000_0002);
    step(ex_stim(6'h0b, 32'h1c00_0300, 32'h7777_7777));
    chk_const("badv_keep", 14'h007, 32'h8000_0002);

    // one-shot timer
    do_reset();
    step(wr_stim(14'h041, 32'hffff_ffff, 32'h9));
    chk_const("os_tval_load", 14'h042, 32'h8);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      step(idle());
      rd(14'h005, v);
      if (v[11]) first = k;
    end
    chk("os_ti_delay", 32'(first), 32'd9);
    chk_const("os_tval_stop", 14'h042, 32'hffff_ffff);
    step(idle());
    chk_const("os_tval_hold", 14'h042, 32'hffff_ffff);

    // periodic timer, TICLR clears unless it meets ti_set
    do_reset();
    step(wr_stim(14'h004, 32'hffff_ffff, 32'h800));
    step(wr_stim(14'h000, 32'h4, 32'h4));
    step(wr_stim(14'h041, 32'hffff_ffff, 32'hb));
    for (int k = 1; k <= 40; k++) begin
      s = idle();
      if (k == 10 || k == 19 || k == 36 || k == 37)
        s = wr_stim(14'h044, 32'h1, 32'h1);
      step(s);
      exp_hi = (k == 9) || (k == 18) || (k >= 27 && k <= 36);
      chk($sformatf("per_has_int_k%0d", k),
          {31'b0, has_int}, {31'b0, exp_hi});
    end

    // async reset mid-countdown
    do_reset();
    step(wr_stim(14'h000, 32'h3, 32'h3));
    step(wr_stim(14'h041, 32'hffff_ffff, 32'h9));
    step(idle());
    step(idle());
    chk_const("ar_tval_mid", 14'h042, 32'h6);
    #20;
    resetn = 0;
    #1;
    chk_const("ar_tval", 14'h042, 32'hffff_ffff);
    chk_const("ar_crmd", 14'h000, 32'h8);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.hw = 8'($urandom());
      s.ipi = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 99)) inside
        [0:5]: begin
          s.ex = 1;
          s.ecode = ($urandom_range(0, 1) == 1) ?
                    6'(8 + $urandom_range(0, 1)) : 6'($urandom());
          s.esub = 9'($urandom());
          s.pc = $urandom();
          s.vaddr = $urandom();
        end
        [6:9]: s.ertn = 1;
        default: ;
      endcase
      if ($urandom_range(0, 99) < 60) begin
        s.we = 1;
        s.num = addrs[$urandom_range(0, 17)];
        s.mask = ($urandom_range(0, 1) == 1) ? 32'hffff_ffff : $urandom();
        s.wval = $urandom();
        if (s.num == 14'h041) s.wval = 32'($urandom_range(0, 40));
      end
      step(s);
      chk_out();
      for (int j = 0; j < 3; j++)
        chk_rd("rand", addrs[$urandom_range(0, 17)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
